// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and types for the 16-bit bus-based CPU:
//                word width, register count, ALU operation codes, opcodes
//                and control-FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int WORD = 16;
    localparam int NREG = 8;

    // ALU operation select, presented on alu_op
    localparam logic [1:0] ALU_NOP = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;

    // Opcodes held in IR[15:12]
    localparam logic [3:0] OP_MV  = 4'b0000;
    localparam logic [3:0] OP_MVI = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;

    // Control FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_e;

    // Only the four lowest opcodes are implemented
    function automatic logic is_legal(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_ctrl_dec3to8.sv
`default_nettype none
// ============================================================================
//  Module      : dec3to8
//  Description : 3-bit to 8-bit one-hot decoder with enable. Output is all
//                zeros when disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module dec3to8 (
    input  logic       en_i,
    input  logic [2:0] sel_i,
    output logic [7:0] onehot_o
);

    // One-hot decode of the selected register index
    always_comb begin
        onehot_o = 8'b0;
        if (en_i) begin
            onehot_o = 8'b1 << sel_i;
        end
    end

endmodule : dec3to8
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl
//  Description : Control-unit FSM for the 16-bit bus-based CPU. Latches an
//                instruction, then sequences MV / MVI / ADD / SUB by driving
//                bus sources, bus sinks and the ALU operation select.
//                Optional macro CTRL_ERR_EN adds a sticky err output that
//                flags execution of an illegal opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            run,
    input  logic [WORD-1:0] instr,
    output logic            ir_load,
    output logic [NREG-1:0] r_out,
    output logic [NREG-1:0] r_in,
    output logic            din_out,
    output logic            a_in,
    output logic            g_in,
    output logic            g_out,
    output logic [1:0]      alu_op,
    output logic            done
`ifdef CTRL_ERR_EN
    ,
    output logic            err
`endif
);

    state_e          state_q;
    logic [WORD-1:0] ir_q;

    logic [3:0]      opcode;
    logic [7:0]      rx_oh;
    logic [7:0]      ry_oh;
    logic            unused_ir_lo;

    assign opcode       = ir_q[15:12];
    assign unused_ir_lo = ^ir_q[5:0];

    dec3to8 u_dec_rx (
        .en_i     (1'b1),
        .sel_i    (ir_q[11:9]),
        .onehot_o (rx_oh)
    );

    dec3to8 u_dec_ry (
        .en_i     (1'b1),
        .sel_i    (ir_q[8:6]),
        .onehot_o (ry_oh)
    );

    // State register and instruction register; IR only loads from IDLE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        ir_q    <= instr;
                        state_q <= S_T1;
                    end
                end
                S_T1: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        state_q <= S_T2;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_T2:    state_q <= S_T3;
                S_T3:    state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Control decode of (state, IR). Reset forces IDLE asynchronously, so
    // only ir_load (which also depends on run) needs explicit gating.
    always_comb begin
        ir_load = 1'b0;
        r_out   = '0;
        r_in    = '0;
        din_out = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        g_out   = 1'b0;
        alu_op  = ALU_NOP;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                ir_load = run & resetn;
            end
            S_T1: begin
                case (opcode)
                    OP_MV: begin
                        r_out = ry_oh;
                        r_in  = rx_oh;
                        done  = 1'b1;
                    end
                    OP_MVI: begin
                        din_out = 1'b1;
                        r_in    = rx_oh;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        r_out = rx_oh;
                        a_in  = 1'b1;
                    end
                    // Illegal opcode: complete without touching the bus
                    default: done = 1'b1;
                endcase
            end
            S_T2: begin
                r_out  = ry_oh;
                g_in   = 1'b1;
                alu_op = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
            end
            S_T3: begin
                g_out = 1'b1;
                r_in  = rx_oh;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CTRL_ERR_EN
    logic err_q;

    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (state_q == S_T1 && !is_legal(opcode)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule : cpu_ctrl
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_ctrl
//  Description : Self-checking bench for cpu_ctrl. Per-cycle vector table of
//                {run, instr, expected outputs} plus directed sequences for
//                reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl;

    logic        clk;
    logic        resetn;
    logic        run;
    logic [15:0] instr;
    logic        ir_load;
    logic [7:0]  r_out;
    logic [7:0]  r_in;
    logic        din_out;
    logic        a_in;
    logic        g_in;
    logic        g_out;
    logic [1:0]  alu_op;
    logic        done;
`ifdef CTRL_ERR_EN
    logic        err;
`endif

    int errors = 0;
    int checks = 0;

    cpu_ctrl dut (
        .clk     (clk),
        .resetn  (resetn),
        .run     (run),
        .instr   (instr),
        .ir_load (ir_load),
        .r_out   (r_out),
        .r_in    (r_in),
        .din_out (din_out),
        .a_in    (a_in),
        .g_in    (g_in),
        .g_out   (g_out),
        .alu_op  (alu_op),
        .done    (done)
`ifdef CTRL_ERR_EN
        ,
        .err     (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {ir_load, r_out, r_in, din_out, a_in, g_in, g_out, alu_op, done}
    function automatic logic [23:0] pk(input logic il, input logic [7:0] ro,
                                       input logic [7:0] ri, input logic dn_o,
                                       input logic a, input logic gi,
                                       input logic go, input logic [1:0] alu,
                                       input logic dn);
        return {il, ro, ri, dn_o, a, gi, go, alu, dn};
    endfunction

    typedef struct {
        logic        run;
        logic [15:0] instr;
        logic [23:0] exp;
        logic        err;
    } vec_t;

    vec_t vec [23];

    task automatic check_outs(input string name, input logic [23:0] exp);
        logic [23:0] got;
        got = pk(ir_load, r_out, r_in, din_out, a_in, g_in, g_out, alu_op, done);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got il=%b ro=%b ri=%b din=%b a=%b gi=%b go=%b alu=%b dn=%b, want il=%b ro=%b ri=%b din=%b a=%b gi=%b go=%b alu=%b dn=%b",
                     name, got[23], got[22:15], got[14:7], got[6], got[5], got[4], got[3], got[2:1], got[0],
                     exp[23], exp[22:15], exp[14:7], exp[6], exp[5], exp[4], exp[3], exp[2:1], exp[0]);
        end
    endtask

`ifdef CTRL_ERR_EN
    task automatic check_err(input string name, input logic exp);
        checks++;
        if (err !== exp) begin
            errors++;
            $display("FAIL %s: err got %b want %b", name, err, exp);
        end
    endtask
`endif

    initial begin
        logic [23:0] z;
        z = pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0);

        // MVI R2
        vec[0]  = '{1'b0, 16'h0000, z, 1'b0};
        vec[1]  = '{1'b1, 16'h1400, pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0), 1'b0};
        vec[2]  = '{1'b0, 16'h0000, pk(0, 8'h00, 8'h04, 1, 0, 0, 0, 2'b00, 1), 1'b0};
        vec[3]  = '{1'b0, 16'h0000, z, 1'b0};
        // ADD R1,R2 with run held high and instr changing mid-instruction
        vec[4]  = '{1'b1, 16'h2280, pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0), 1'b0};
        vec[5]  = '{1'b1, 16'h1400, pk(0, 8'h02, 8'h00, 0, 1, 0, 0, 2'b00, 0), 1'b0};
        vec[6]  = '{1'b1, 16'h1400, pk(0, 8'h04, 8'h00, 0, 0, 1, 0, 2'b01, 0), 1'b0};
        vec[7]  = '{1'b1, 16'h1400, pk(0, 8'h00, 8'h02, 0, 0, 0, 1, 2'b00, 1), 1'b0};
        // MV R0,R7 back-to-back, then SUB R3,R3 back-to-back
        vec[8]  = '{1'b1, 16'h01C0, pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0), 1'b0};
        vec[9]  = '{1'b1, 16'h36C0, pk(0, 8'h80, 8'h01, 0, 0, 0, 0, 2'b00, 1), 1'b0};
        vec[10] = '{1'b1, 16'h36C0, pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0), 1'b0};
        vec[11] = '{1'b0, 16'h0000, pk(0, 8'h08, 8'h00, 0, 1, 0, 0, 2'b00, 0), 1'b0};
        vec[12] = '{1'b0, 16'h0000, pk(0, 8'h08, 8'h00, 0, 0, 1, 0, 2'b10, 0), 1'b0};
        vec[13] = '{1'b0, 16'h0000, pk(0, 8'h00, 8'h08, 0, 0, 0, 1, 2'b00, 1), 1'b0};
        vec[14] = '{1'b0, 16'h0000, z, 1'b0};
        // Illegal opcode 0xF
        vec[15] = '{1'b1, 16'hF000, pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0), 1'b0};
        vec[16] = '{1'b0, 16'h0000, pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1), 1'b0};
        vec[17] = '{1'b0, 16'h0000, z, 1'b1};
        // ADD R1,R1
        vec[18] = '{1'b1, 16'h2240, pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0), 1'b1};
        vec[19] = '{1'b0, 16'h0000, pk(0, 8'h02, 8'h00, 0, 1, 0, 0, 2'b00, 0), 1'b1};
        vec[20] = '{1'b0, 16'h0000, pk(0, 8'h02, 8'h00, 0, 0, 1, 0, 2'b01, 0), 1'b1};
        vec[21] = '{1'b0, 16'h0000, pk(0, 8'h00, 8'h02, 0, 0, 0, 1, 2'b00, 1), 1'b1};
        vec[22] = '{1'b0, 16'h0000, z, 1'b1};

        // Reset held with run asserted: everything must be quiet
        resetn = 1'b0;
        run    = 1'b1;
        instr  = 16'h2280;
        @(negedge clk);
        #1 check_outs("reset_hold", z);
`ifdef CTRL_ERR_EN
        check_err("reset_err", 1'b0);
`endif
        @(negedge clk);
        resetn = 1'b1;
        #1 check_outs("release_irload", pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        @(negedge clk);
        run = 1'b0;
        #1 check_outs("add_t1", pk(0, 8'h02, 8'h00, 0, 1, 0, 0, 2'b00, 0));

        // Abort ADD in T2 with an asynchronous reset
        @(posedge clk);
        #2 check_outs("add_t2", pk(0, 8'h04, 8'h00, 0, 0, 1, 0, 2'b01, 0));
        resetn = 1'b0;
        #1 check_outs("async_reset", z);
        @(posedge clk);
        #1 check_outs("reset_no_done", z);
        @(negedge clk);
        resetn = 1'b1;
        run    = 1'b1;
        instr  = 16'h0000;
        #1 check_outs("mv00_load", pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
        @(negedge clk);
        run = 1'b0;
        #1 check_outs("mv00_t1", pk(0, 8'h01, 8'h01, 0, 0, 0, 0, 2'b00, 1));

        // Table-driven per-cycle vectors
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            run   = vec[i].run;
            instr = vec[i].instr;
            #1 check_outs($sformatf("vec%0d", i), vec[i].exp);
`ifdef CTRL_ERR_EN
            check_err($sformatf("vec%0d_err", i), vec[i].err);
`endif
        end

`ifdef CTRL_ERR_EN
        // Sticky flag clears only with reset
        @(negedge clk);
        resetn = 1'b0;
        #1 check_err("err_cleared", 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cpu_ctrl
`default_nettype wire

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Control-unit FSM for the 16-bit bus-based CPU.
- Latches an instruction word, then drives the shared-bus sources (register outputs, external data, G) and sinks (register inputs, A, G).
- Drives alu_op to the ALU that computes G = A op bus.
- Sequences MV, MVI, ADD and SUB over 1–3 execute cycles and pulses done at completion.

Parameters:
- WORD, 16: instruction and datapath word width.
- NREG, 8: number of general registers. Fixed at 8 by the 3-bit register fields.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- run  in  1  start request, sampled only in IDLE.
- instr  in  WORD  instruction word, sampled into IR when ir_load=1.
- ir_load  out  1  IR capture strobe, for observability.
- r_out  out  NREG  one-hot; register i drives the bus.
- r_in  out  NREG  one-hot; register i loads from the bus.
- din_out  out  1  external data drives the bus.
- a_in  out  1  A register loads from the bus.
- g_in  out  1  G register loads the ALU result.
- g_out  out  1  G drives the bus.
- alu_op  out  2  00 NOP, 01 ADD, 10 SUB.
- done  out  1  single-cycle instruction-complete pulse.
- err  out  1  present only with CTRL_ERR_EN.

Behaviour:
- One clock. Reset is asynchronous and active-low: resetn=0 forces state IDLE and IR=0 immediately.
- While resetn=0, all outputs are forced to 0, including ir_load.
- Instruction format:
  - IR[15:12] opcode: 0000 MV, 0001 MVI, 0010 ADD, 0011 SUB.
  - IR[11:9] Rx, the destination and first operand.
  - IR[8:6] Ry, the second operand.
  - IR[5:0] ignored.
- States: IDLE, T1, T2, T3, in a two-bit register.
- All outputs are combinational decodes of (state, IR). They are glitch-free relative to clk and valid within the same cycle.
- IDLE: ir_load=run. If run=1, IR<=instr and go to T1; otherwise stay in IDLE.
- T1:
  - MV: r_out[Ry]=1, r_in[Rx]=1, done=1, then IDLE.
  - MVI: din_out=1, r_in[Rx]=1, done=1, then IDLE.
  - ADD/SUB: r_out[Rx]=1, a_in=1, then T2.
- T2: r_out[Ry]=1, g_in=1, alu_op=01 for ADD or 10 for SUB, then T3.
- T3: g_out=1, r_in[Rx]=1, done=1, then IDLE.
- Latency, measured from the run cycle:
  - MV/MVI: done in the next cycle.
  - ADD/SUB: done 3 cycles after the run cycle.
- Back-to-back: run=1 in the cycle after done starts the next instruction. There is no dead cycle beyond IDLE.
- alu_op=00 in every state other than T2.
- Bus exclusivity: at most one of r_out bits, din_out or g_out is asserted per cycle. At most one r_in bit is asserted.
- run and instr are ignored outside IDLE. IR stays stable for the whole instruction.
- Rx==Ry is legal:
  - MV Rx,Rx rewrites the same value.
  - ADD Rx,Rx doubles Rx.
- Illegal opcodes 0100–1111: T1 asserts done only (no bus driver, no load), then IDLE.
- Reset mid-instruction aborts it. No done pulse occurs, and the next instruction starts from IDLE after release.

Optional Feature:
- Macro: CTRL_ERR_EN.
- When defined:
  - Output err exists.
  - err is sticky: it goes to 1 in the cycle after any illegal opcode's T1 and holds until resetn=0.
  - An illegal opcode additionally asserts no other outputs beyond done.
- When undefined: the err port and its flop are absent, and illegal opcodes behave as above.

Decomposition:
- Shared package cpu_pkg:
  - WORD.
  - ALU_NOP/ALU_ADD/ALU_SUB encodings.
  - Opcode constants OP_MV/OP_MVI/OP_ADD/OP_SUB.
  - FSM state encodings.
- The ALU testbench and datapath also import cpu_pkg.
- One sub-module: dec3to8, a 3-bit to 8-bit one-hot decoder with enable, instantiated twice (Rx and Ry).

Test Plan:
- Reset: hold resetn=0 with run=1 and instr=0x2280 → all outputs 0. After release, ir_load=1 the same cycle and state enters T1 on the next edge.
- MVI R2 (instr=0x1400, run pulse) → T1: din_out=1, r_in=8'b0000_0100, done=1, alu_op=00. The next cycle is IDLE with all outputs 0.
- ADD R1,R2 (0x2280):
  - T1: r_out=8'b0000_0010, a_in=1.
  - T2: r_out=8'b0000_0100, g_in=1, alu_op=01.
  - T3: g_out=1, r_in=8'b0000_0010, done=1.
  - run held high through T1–T3 does not reload IR.
- SUB R3,R3 (0x36C0) issued back-to-back after MV R0,R7 (0x01C0):
  - MV T1: r_out=8'b1000_0000, r_in=8'b0000_0001, done=1.
  - SUB: alu_op=10 only in T2; done at T3.
- Reset asserted during T2 of ADD → outputs go 0 without a clock edge, and no done occurs. After release, run with 0x0000 executes MV R0,R0 normally.
- Illegal 0xF000 → T1 done=1, all r_in/r_out/din_out/g_out=0. With CTRL_ERR_EN, err=1 from the next cycle, sticky until reset.
